// File: rtl/axi_timer.sv
// rtl/axi_timer.sv - AXI4-Lite timer/compare peripheral with prescaler, auto-reload and level irq
module axi_timer #(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arvalid_i,
    output logic              aready_o,
    input  logic [ADDR_W-1:0] araddr_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [31:0]       rdata_o,
    output logic [1:0]        rresp_o,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [31:0]       wdata_i,
    output logic              bvalid_o,
    input  logic              bready_i,
    output logic [1:0]        bresp_o,
    output logic              irq_o
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t    r_w_state;
    w_state_t    w_w_state_nxt;
    r_state_t    r_r_state;
    r_state_t    w_r_state_nxt;

    logic [2:0]  r_ctrl;
    logic        r_match;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [15:0] r_prescale;
    logic [15:0] r_pre_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [1:0]  r_bresp;

    logic        w_wr_en;
    logic [2:0]  w_wr_off;
    logic        w_wr_err;
    logic        w_count_wr;
    logic        w_status_clr;
    logic        w_rd_en;
    logic [2:0]  w_rd_off;
    logic [31:0] w_rd_val;
    logic        w_tick;
    logic        w_hit;
    logic        w_unused;

    // Address bits below the word offset (and above it, for wider buses) carry no meaning here.
    assign w_unused = ^{awaddr_i, araddr_i};

    // The write address/data are still held by the master while in W_ACK, so they are used directly.
    assign w_wr_en      = (r_w_state == W_ACK);
    assign w_wr_off     = awaddr_i[4:2];
    assign w_wr_err     = (w_wr_off > OFF_PRESCALE);
    assign w_count_wr   = w_wr_en && (w_wr_off == OFF_COUNT);
    assign w_status_clr = w_wr_en && (w_wr_off == OFF_STATUS) && wdata_i[0];

    assign w_rd_en  = (r_r_state == R_ACK);
    assign w_rd_off = araddr_i[4:2];

    assign w_tick = r_ctrl[0] && (r_pre_cnt == r_prescale);
    assign w_hit  = w_tick && (r_count == r_compare);

    assign irq_o   = r_match && r_ctrl[2];
    assign rdata_o = r_rdata;
    assign rresp_o = r_rresp;
    assign bresp_o = r_bresp;

    // Write channel state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_w_state <= W_IDLE;
        else        r_w_state <= w_w_state_nxt;
    end

    // Write channel next state and handshake outputs: address and data are taken together.
    always_comb begin
        w_w_state_nxt = r_w_state;
        awready_o     = 1'b0;
        wready_o      = 1'b0;
        bvalid_o      = 1'b0;
        case (r_w_state)
            W_IDLE: if (awvalid_i && wvalid_i) w_w_state_nxt = W_ACK;
            W_ACK: begin
                awready_o     = 1'b1;
                wready_o      = 1'b1;
                w_w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) w_w_state_nxt = W_IDLE;
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    // Read channel state register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_r_state <= R_IDLE;
        else        r_r_state <= w_r_state_nxt;
    end

    // Read channel next state and handshake outputs.
    always_comb begin
        w_r_state_nxt = r_r_state;
        aready_o      = 1'b0;
        rvalid_o      = 1'b0;
        case (r_r_state)
            R_IDLE: if (arvalid_i) w_r_state_nxt = R_ACK;
            R_ACK: begin
                aready_o      = 1'b1;
                w_r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid_o = 1'b1;
                if (rready_i) w_r_state_nxt = R_IDLE;
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        w_rd_val = 32'd0;
        case (w_rd_off)
            OFF_CTRL:     w_rd_val = {29'd0, r_ctrl};
            OFF_STATUS:   w_rd_val = {31'd0, r_match};
            OFF_COUNT:    w_rd_val = r_count;
            OFF_COMPARE:  w_rd_val = r_compare;
            OFF_PRESCALE: w_rd_val = {16'd0, r_prescale};
            default:      w_rd_val = 32'd0;
        endcase
    end

    // Read data and response are captured once and held until the R handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rdata <= 32'd0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_en) begin
            r_rdata <= w_rd_val;
            r_rresp <= (w_rd_off > OFF_PRESCALE) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Write response is decided in the accept cycle and held through W_RESP.
    always_ff @(posedge clk_i) begin
        if (!rst_i)       r_bresp <= RESP_OKAY;
        else if (w_wr_en) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Plain configuration registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ctrl     <= 3'd0;
            r_compare  <= 32'hFFFF_FFFF;
            r_prescale <= 16'd0;
        end else if (w_wr_en) begin
            if (w_wr_off == OFF_CTRL)     r_ctrl     <= wdata_i[2:0];
            if (w_wr_off == OFF_COMPARE)  r_compare  <= wdata_i;
            if (w_wr_off == OFF_PRESCALE) r_prescale <= wdata_i[15:0];
        end
    end

    // Prescale counter: held at zero while disabled; a new PRESCALE below it lets it run to 0xFFFF and wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_i)               r_pre_cnt <= 16'd0;
        else if (!r_ctrl[0])      r_pre_cnt <= 16'd0;
        else if (w_tick)          r_pre_cnt <= 16'd0;
        else                      r_pre_cnt <= r_pre_cnt + 16'd1;
    end

    // Main count: a bus write to COUNT overrides (and discards) a coincident tick.
    always_ff @(posedge clk_i) begin
        if (!rst_i)          r_count <= 32'd0;
        else if (w_count_wr) r_count <= wdata_i;
        else if (w_tick)     r_count <= (w_hit && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
    end

    // Match flag: a new match beats a coincident write-1-to-clear.
    always_ff @(posedge clk_i) begin
        if (!rst_i)                     r_match <= 1'b0;
        else if (w_hit && !w_count_wr)  r_match <= 1'b1;
        else if (w_status_clr)          r_match <= 1'b0;
    end

endmodule

// File: tb/tb_axi_timer.sv
// tb/tb_axi_timer.sv - randomized self-checking bench for axi_timer against a behavioural model
module tb_axi_timer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        arvalid_i, aready_o, rvalid_o, rready_i;
    logic [4:0]  araddr_i, awaddr_i;
    logic [31:0] rdata_o, wdata_i;
    logic [1:0]  rresp_o, bresp_o;
    logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i, irq_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit irq_chk_en = 0;

    // Behavioural model of the programmer-visible state.
    logic [2:0]  m_ctrl;
    logic        m_match;
    logic [31:0] m_count, m_compare;
    logic [15:0] m_prescale, m_pre;
    bit          m_wr_go = 0;
    logic [2:0]  m_wr_off;
    logic [31:0] m_wr_data;

    axi_timer #(.ADDR_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .arvalid_i(arvalid_i), .aready_o(aready_o), .araddr_i(araddr_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {29'd0, m_ctrl};
            3'd1:    return {31'd0, m_match};
            3'd2:    return m_count;
            3'd3:    return m_compare;
            3'd4:    return {16'd0, m_prescale};
            default: return 32'd0;
        endcase
    endfunction

    // Model advances one clock: ticks every (PRESCALE+1) enabled cycles, bus writes applied at the accept edge.
    always @(posedge clk_i) begin
        logic        tick, hit, lost;
        logic [32:0] sum;
        logic [2:0]  n_ctrl;
        logic        n_match;
        logic [31:0] n_count, n_compare;
        logic [15:0] n_prescale, n_pre;
        if (!rst_i) begin
            m_ctrl <= 3'd0; m_match <= 1'b0; m_count <= 32'd0;
            m_compare <= 32'hFFFF_FFFF; m_prescale <= 16'd0; m_pre <= 16'd0;
        end else begin
            tick = m_ctrl[0] && (m_pre == m_prescale);
            hit  = tick && (m_count == m_compare);
            lost = m_wr_go && (m_wr_off == 3'd2);
            n_pre = (m_ctrl[0] && !tick) ? 16'((32'(m_pre) + 1) % 65536) : 16'd0;
            sum = {1'b0, m_count} + 33'd1;
            n_count    = tick ? ((hit && m_ctrl[1]) ? 32'd0 : sum[31:0]) : m_count;
            n_match    = m_match;
            n_ctrl     = m_ctrl;
            n_compare  = m_compare;
            n_prescale = m_prescale;
            if (m_wr_go) begin
                case (m_wr_off)
                    3'd0: n_ctrl = m_wr_data[2:0];
                    3'd1: if (m_wr_data[0]) n_match = 1'b0;
                    3'd2: n_count = m_wr_data;
                    3'd3: n_compare = m_wr_data;
                    3'd4: n_prescale = m_wr_data[15:0];
                    default: ;
                endcase
            end
            if (hit && !lost) n_match = 1'b1;
            m_ctrl <= n_ctrl; m_match <= n_match; m_count <= n_count;
            m_compare <= n_compare; m_prescale <= n_prescale; m_pre <= n_pre;
        end
    end

    // Interrupt level must track the model every cycle.
    always @(negedge clk_i) begin
        if (irq_chk_en) check_eq("irq", irq_o, m_match & m_ctrl[2]);
    end

    task automatic bus_write(input logic [2:0] off, input logic [31:0] data, input int aw_lead, input int b_wait);
        logic [1:0] exp_resp;
        exp_resp = (off > 3'd4) ? 2'b10 : 2'b00;
        @(negedge clk_i);
        awvalid_i = 1'b1; awaddr_i = {off, 2'b00};
        repeat (aw_lead) begin
            @(negedge clk_i);
            check_eq("aw_alone_no_ready", {awready_o, wready_o}, 2'b00);
        end
        wvalid_i = 1'b1; wdata_i = data;
        @(negedge clk_i);
        check_eq("w_ack", {awready_o, wready_o, bvalid_o}, 3'b110);
        m_wr_off = off; m_wr_data = data; m_wr_go = 1;
        @(negedge clk_i);
        m_wr_go = 0; awvalid_i = 1'b0; wvalid_i = 1'b0;
        check_eq("w_ack_once", {awready_o, wready_o}, 2'b00);
        check_eq("bvalid", bvalid_o, 1'b1);
        check_eq("bresp", bresp_o, exp_resp);
        repeat (b_wait) begin
            @(negedge clk_i);
            check_eq("bvalid_hold", {bvalid_o, bresp_o}, {1'b1, exp_resp});
        end
        bready_i = 1'b1;
        @(negedge clk_i);
        bready_i = 1'b0;
        check_eq("bvalid_drop", bvalid_o, 1'b0);
    endtask

    task automatic bus_read(input logic [2:0] off, input int r_wait, output logic [31:0] data);
        logic [31:0] exp;
        logic [1:0]  exp_resp;
        exp_resp = (off > 3'd4) ? 2'b10 : 2'b00;
        @(negedge clk_i);
        arvalid_i = 1'b1; araddr_i = {off, 2'b00};
        @(negedge clk_i);
        check_eq("ar_ack", {aready_o, rvalid_o}, 2'b10);
        exp = model_read(off);
        @(negedge clk_i);
        arvalid_i = 1'b0;
        check_eq("rvalid", {aready_o, rvalid_o}, 2'b01);
        check_eq("rdata", rdata_o, exp);
        check_eq("rresp", rresp_o, exp_resp);
        data = rdata_o;
        repeat (r_wait) begin
            @(negedge clk_i);
            check_eq("rdata_hold", {rvalid_o, rresp_o, rdata_o}, {1'b1, exp_resp, exp});
        end
        rready_i = 1'b1;
        @(negedge clk_i);
        rready_i = 1'b0;
        check_eq("rvalid_drop", rvalid_o, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        rst_i = 1'b0;
        arvalid_i = 1'b1; awvalid_i = 1'b1; wvalid_i = 1'b1;
        araddr_i = '0; awaddr_i = '0; wdata_i = 32'h7;
        rready_i = 1'b0; bready_i = 1'b0;

        // Reset with all request valids asserted.
        repeat (3) begin
            @(negedge clk_i);
            check_eq("reset_outputs",
                     {aready_o, rvalid_o, awready_o, wready_o, bvalid_o, irq_o, rdata_o, rresp_o, bresp_o}, '0);
        end
        rst_i = 1'b1; arvalid_i = 1'b0; awvalid_i = 1'b0; wvalid_i = 1'b0;
        irq_chk_en = 1;
        bus_read(3'd3, 0, rd);
        check_eq("reset_compare", rd, 32'hFFFF_FFFF);
        bus_read(3'd2, 0, rd);
        check_eq("reset_count", rd, 32'd0);

        // Write handshake with AW leading W, slow B acceptance, and an unmapped write.
        bus_write(3'd4, 32'd2, 2, 3);
        bus_write(3'd5, 32'hDEAD_BEEF, 0, 1);
        for (int i = 0; i < 8; i++) bus_read(3'(i), 0, rd);

        // Auto-reload with irq enabled, then clear the flag.
        bus_write(3'd0, 32'd0, 0, 0);
        bus_write(3'd4, 32'd0, 0, 0);
        bus_write(3'd3, 32'd3, 0, 0);
        bus_write(3'd2, 32'd0, 0, 0);
        bus_write(3'd1, 32'd1, 0, 0);
        bus_write(3'd0, 32'd7, 0, 0);
        for (int i = 0; i < 6; i++) bus_read(3'd2, i % 2, rd);
        bus_read(3'd1, 0, rd);
        check_eq("autoreload_match", rd, 32'd1);
        bus_write(3'd0, 32'd6, 0, 0);
        bus_write(3'd1, 32'd1, 0, 0);
        bus_read(3'd1, 0, rd);
        check_eq("w1c_clears", rd, 32'd0);

        // Prescaled free-run across the 32-bit wrap, irq disabled.
        bus_write(3'd0, 32'd0, 0, 0);
        bus_write(3'd4, 32'd4, 0, 0);
        bus_write(3'd2, 32'hFFFF_FFFE, 0, 0);
        bus_write(3'd3, 32'd5, 0, 0);
        bus_write(3'd0, 32'd1, 0, 0);
        for (int i = 0; i < 14; i++) bus_read(3'd2, 0, rd);
        bus_read(3'd1, 0, rd);
        check_eq("prescale_match", rd, 32'd1);

        // Collisions: W1C against a match every cycle, COUNT write against a tick.
        bus_write(3'd0, 32'd0, 0, 0);
        bus_write(3'd4, 32'd0, 0, 0);
        bus_write(3'd3, 32'd0, 0, 0);
        bus_write(3'd2, 32'd0, 0, 0);
        bus_write(3'd0, 32'd3, 0, 0);
        bus_write(3'd1, 32'd1, 0, 0);
        bus_read(3'd1, 0, rd);
        check_eq("w1c_vs_match", rd, 32'd1);
        bus_write(3'd3, 32'hFFFF_FFFF, 0, 0);
        bus_write(3'd0, 32'd1, 0, 0);
        bus_write(3'd2, 32'h100, 0, 0);
        bus_write(3'd0, 32'd0, 0, 0);
        bus_read(3'd2, 0, rd);
        check_eq("count_write_vs_tick", rd, 32'h104);

        // Read of a running COUNT while a write sits in its response phase.
        bus_write(3'd0, 32'd1, 0, 0);
        fork
            bus_write(3'd3, 32'h1234, 0, 10);
            begin
                repeat (3) @(negedge clk_i);
                bus_read(3'd2, 1, rd);
            end
        join

        // Randomized register traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0: bus_write(3'd0, 32'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 3));
                1: bus_write(3'd1, 32'($urandom_range(0, 1)), 0, $urandom_range(0, 2));
                2: bus_write(3'd2, m_compare - 32'($urandom_range(0, 12)), $urandom_range(0, 2), 0);
                3: bus_write(3'd3, m_count + 32'($urandom_range(0, 20)), 0, $urandom_range(0, 2));
                4: bus_write(3'd4, 32'($urandom_range(0, 3)), $urandom_range(0, 1), 0);
                5: bus_write(3'($urandom_range(5, 7)), $urandom, 0, 0);
                default: bus_read(3'($urandom_range(0, 7)), $urandom_range(0, 3), rd);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        for (int i = 0; i < 5; i++) bus_read(3'(i), 0, rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
